// File: rtl/apb_uart_fifo.sv
// APB UART slave with TX/RX FIFOs, parity, sticky error flags.
// Define APB_UART_IRQ_EN to add the level interrupt output irq.
module apb_uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int DIV_RST    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        txd,
    input  logic [3:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
`ifdef APB_UART_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(3);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
`ifdef APB_UART_IRQ_EN
    localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
    localparam logic [5:0] CTRL_MASK = 6'h0F;
`endif

    logic wr, rd_setup, rd_acc, a_ctrl, a_div, a_stat, a_data;
    assign wr       = psel & penable & pwrite;
    assign rd_setup = psel & !penable & !pwrite;
    assign rd_acc   = psel & penable & !pwrite;
    assign a_ctrl   = paddr == 4'h0;
    assign a_div    = paddr == 4'h4;
    assign a_stat   = paddr == 4'h8;
    assign a_data   = paddr == 4'hC;
    assign pready   = 1'b1;
    assign pslverr  = 1'b0;

    logic [5:0] ctrl_q;
    logic [DIV_W-1:0] div_q, eff_div, rx_half;
    logic [DIV_W:0] half_w;
    logic ovr_q, perr_q, ferr_q, ovr_d, perr_d, ferr_d;
    logic [31:0] prdata_q, rd_mux;
    logic rd_ok_q;

    assign eff_div = (div_q < MIN_DIV) ? MIN_DIV : div_q;
    assign half_w  = ({1'b0, eff_div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    assign rx_half = half_w[DIV_W-1:0] - ONE;

    logic [DATA_BITS-1:0] txm_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rxm_q [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_BITS-1:0] tx_head, rx_head;

    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                      (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                      (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign tx_head  = txm_q[tx_rp_q[AW-1:0]];
    assign rx_head  = rxm_q[rx_rp_q[AW-1:0]];
    assign tx_push  = wr & a_data & !tx_full;
    // rd_ok_q ties the pop to what the setup phase actually returned
    assign rx_pop   = rd_acc & a_data & rd_ok_q;

    logic [2:0] tx_st_q, tx_st_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [BW-1:0] tx_bit_q, tx_bit_d;
    logic tx_par_q, tx_par_d, txd_q, txd_d, tx_go;

    assign tx_go = ctrl_q[0] & !tx_empty;
    assign txd   = txd_q;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_sh_d  = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_par_d = tx_par_q;
        txd_d    = txd_q;
        tx_pop   = 1'b0;
        if (tx_st_q != ST_IDLE && tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - ONE;
        end else begin
            tx_cnt_d = eff_div;
            unique case (tx_st_q)
                ST_IDLE, ST_STOP: begin
                    if (tx_go) begin
                        tx_pop   = 1'b1;
                        tx_st_d  = ST_START;
                        txd_d    = 1'b0;
                        tx_sh_d  = tx_head;
                        tx_par_d = ^tx_head ^ ctrl_q[3];
                    end else begin
                        tx_st_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
                ST_START: begin
                    tx_st_d  = ST_DATA;
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = '0;
                end
                ST_DATA: begin
                    if (tx_bit_q == LAST) begin
                        tx_st_d = ctrl_q[2] ? ST_PARITY : ST_STOP;
                        txd_d   = ctrl_q[2] ? tx_par_q : 1'b1;
                    end else begin
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end
                ST_PARITY: begin
                    tx_st_d = ST_STOP;
                    txd_d   = 1'b1;
                end
                default: begin
                    tx_st_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    logic [2:0] rx_st_q, rx_st_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [BW-1:0] rx_bit_q, rx_bit_d;
    logic rx_pbad_q, rx_pbad_d, rx_done, ferr_set, perr_set, ovr_set;

    assign rx_fall = rx_s3_q & !rx_s2_q;
    assign rx_push = rx_done & !rx_full;
    assign ovr_set = rx_done & rx_full;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_sh_d   = rx_sh_q;
        rx_bit_d  = rx_bit_q;
        rx_pbad_d = rx_pbad_q;
        rx_done   = 1'b0;
        ferr_set  = 1'b0;
        perr_set  = 1'b0;
        if (rx_st_q == ST_IDLE) begin
            if (ctrl_q[1] & rx_fall) begin
                rx_st_d   = ST_START;
                rx_cnt_d  = rx_half;
                rx_pbad_d = 1'b0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - ONE;
        end else begin
            rx_cnt_d = eff_div;
            unique case (rx_st_q)
                ST_START: begin
                    rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
                    rx_bit_d = '0;
                end
                ST_DATA: begin
                    rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST) begin
                        rx_st_d = ctrl_q[2] ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end
                ST_PARITY: begin
                    rx_pbad_d = rx_s2_q ^ (^rx_sh_q) ^ ctrl_q[3];
                    rx_st_d   = ST_STOP;
                end
                default: begin
                    rx_st_d  = ST_IDLE;
                    rx_done  = 1'b1;
                    ferr_set = !rx_s2_q;
                    perr_set = rx_pbad_q;
                end
            endcase
        end
    end

    // a set in the same cycle as a W1C clear wins
    assign ovr_d  = (ovr_q  & !(wr & a_stat & pwdata[4])) | ovr_set;
    assign perr_d = (perr_q & !(wr & a_stat & pwdata[5])) | perr_set;
    assign ferr_d = (ferr_q & !(wr & a_stat & pwdata[6])) | ferr_set;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            a_ctrl: rd_mux = 32'(ctrl_q);
            a_div:  rd_mux = 32'(div_q);
            a_stat: rd_mux = {24'd0, tx_st_q != ST_IDLE, ferr_q, perr_q,
                              ovr_q, rx_empty, rx_full, tx_empty, tx_full};
            a_data: rd_mux = rx_empty ? '0 : 32'(rx_head);
            default: rd_mux = '0;
        endcase
    end
    assign prdata = prdata_q;

    always_ff @(posedge clk) begin
        if (tx_push) txm_q[tx_wp_q[AW-1:0]] <= pwdata[DATA_BITS-1:0];
        if (rx_push) rxm_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            div_q     <= DIV_W'(DIV_RST);
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            prdata_q  <= '0;
            rd_ok_q   <= 1'b0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_st_q   <= ST_IDLE;
            tx_cnt_q  <= '0;
            tx_sh_q   <= '0;
            tx_bit_q  <= '0;
            tx_par_q  <= 1'b0;
            txd_q     <= 1'b1;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= ST_IDLE;
            rx_cnt_q  <= '0;
            rx_sh_q   <= '0;
            rx_bit_q  <= '0;
            rx_pbad_q <= 1'b0;
        end else begin
            if (wr & a_ctrl) ctrl_q <= pwdata[5:0] & CTRL_MASK;
            if (wr & a_div) div_q <= pwdata[DIV_W-1:0];
            ovr_q  <= ovr_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            if (rd_setup) begin
                prdata_q <= rd_mux;
                rd_ok_q  <= a_data & !rx_empty;
            end
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            tx_par_q  <= tx_par_d;
            txd_q     <= txd_d;
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_sh_q   <= rx_sh_d;
            rx_bit_q  <= rx_bit_d;
            rx_pbad_q <= rx_pbad_d;
        end
    end

`ifdef APB_UART_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else irq_q <= (ctrl_q[4] & !rx_empty) | (ctrl_q[5] & tx_empty) |
                      (ctrl_q[4] & (ovr_q | perr_q | ferr_q));
    end
    assign irq = irq_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{pwdata, half_w};
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Scoreboard bench for apb_uart_fifo: APB read and TX frame monitors
// pop expected values queued by the directed stimulus.
module tb_apb_uart_fifo;
    logic clk = 1'b0;
    logic rst, rxd, rxd_drv, loop, txd;
    logic [3:0] paddr;
    logic psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic pready, pslverr;
`ifdef APB_UART_IRQ_EN
    logic irq;
`endif

    assign rxd = loop ? txd : rxd_drv;
    always #5 clk = ~clk;

    apb_uart_fifo dut (
`ifdef APB_UART_IRQ_EN
        .irq(irq),
`endif
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd),
        .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    int total = 0;
    int bad = 0;
    int tx_frames = 0;
    logic [31:0] rd_q[$];
    string rd_name_q[$];
    logic [7:0] tx_q[$];
    logic mon_par = 1'b0;
    logic mon_odd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // APB read monitor
    always @(negedge clk) begin
        if (psel && penable && !pwrite) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got 0x%0h expected none", prdata);
            end else begin
                chk(rd_name_q.pop_front(), prdata, rd_q.pop_front());
            end
        end
    end

    // TX serial monitor, 4 clocks per bit
    initial begin
        logic [7:0] b, e;
        logic st, p, s;
        forever begin
            @(negedge txd);
            repeat (2) @(posedge clk);
            #1 st = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(posedge clk);
                #1 b[i] = txd;
            end
            if (mon_par) begin
                repeat (4) @(posedge clk);
                #1 p = txd;
            end else begin
                p = ^b ^ mon_odd;
            end
            repeat (4) @(posedge clk);
            #1 s = txd;
            tx_frames++;
            if (tx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got 0x%0h expected none", b);
            end else begin
                e = tx_q.pop_front();
                chk("tx_frame", {21'd0, st, s, p, b},
                    {21'd0, 1'b0, 1'b1, ^e ^ mon_odd, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input string n, input logic [3:0] a,
                          input logic [31:0] e);
        rd_q.push_back(e);
        rd_name_q.push_back(n);
        @(posedge clk);
        #1 paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int pbit,
                              input logic stopb);
        rxd_drv = 1'b0;
        idle(4);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            idle(4);
        end
        if (pbit >= 0) begin
            rxd_drv = pbit[0];
            idle(4);
        end
        rxd_drv = stopb;
        idle(4);
        rxd_drv = 1'b1;
        idle(8);
    endtask

    initial begin
        int n, f0;
        logic [7:0] lb [3];
        lb[0] = 8'h3C;
        lb[1] = 8'h00;
        lb[2] = 8'hFF;
        rst = 1'b1; loop = 1'b0; rxd_drv = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        idle(3);
        chk("txd_in_reset", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        idle(2);
        apb_rd("ctrl_rst", 4'h0, 32'h0);
        apb_rd("div_rst", 4'h4, 32'hF);
        apb_rd("stat_rst", 4'h8, 32'h0A);
        chk("txd_idle", {31'd0, txd}, 32'd1);
        apb_wr(4'h0, 32'h3F);
`ifdef APB_UART_IRQ_EN
        apb_rd("ctrl_mask", 4'h0, 32'h3F);
`else
        apb_rd("ctrl_mask", 4'h0, 32'h0F);
`endif
        apb_wr(4'h0, 32'h0);

        apb_wr(4'h4, 32'd3);
        apb_rd("div_wr", 4'h4, 32'd3);
        apb_wr(4'h0, 32'h1);
        tx_q.push_back(8'hA5);
        apb_wr(4'hC, 32'hA5);
        n = 0;
        while (txd === 1'b1 && n < 3) begin
            idle(1);
            n++;
        end
        chk("tx_latency", {31'd0, n <= 2 && txd === 1'b0}, 32'd1);
        n = 0;
        while (txd === 1'b0 && n < 20) begin
            idle(1);
            n++;
        end
        chk("start_len", n, 32'd4);
        apb_rd("stat_busy", 4'h8, 32'h8A);
        idle(45);
        apb_rd("stat_txdone", 4'h8, 32'h0A);

        loop = 1'b1; mon_par = 1'b1; mon_odd = 1'b1;
        apb_wr(4'h0, 32'hF);
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(lb[i]);
            apb_wr(4'hC, {24'd0, lb[i]});
        end
        idle(160);
        apb_rd("stat_lb", 4'h8, 32'h02);
        for (int i = 0; i < 3; i++) apb_rd("lb_data", 4'hC, {24'd0, lb[i]});
        apb_rd("stat_lb_end", 4'h8, 32'h0A);

        loop = 1'b0; mon_par = 1'b0; mon_odd = 1'b0;
        apb_wr(4'h0, 32'h0);
        apb_wr(4'h4, 32'h0);
        apb_rd("div_zero", 4'h4, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(8'h30 + 8'(i));
            apb_wr(4'hC, 32'h30 + i);
        end
        apb_rd("stat_txfull", 4'h8, 32'h09);
        f0 = tx_frames;
        apb_wr(4'h0, 32'h1);
        idle(360);
        chk("tx_frame_cnt", tx_frames - f0, 32'd8);
        chk("tx_q_drained", tx_q.size(), 32'd0);
        apb_rd("stat_tx8", 4'h8, 32'h0A);

        apb_wr(4'h0, 32'h2);
        apb_wr(4'h4, 32'd3);
        for (int i = 0; i < 9; i++) send_frame(8'hC0 + 8'(i), -1, 1'b1);
        apb_rd("stat_rxfull", 4'h8, 32'h16);
        apb_wr(4'h8, 32'h10);
        apb_rd("stat_ovr_clr", 4'h8, 32'h06);
        for (int i = 0; i < 8; i++) apb_rd("rx_data", 4'hC, 32'hC0 + i);
        apb_rd("stat_rx_drained", 4'h8, 32'h0A);
        apb_rd("rx_empty_read", 4'hC, 32'h0);

        send_frame(8'h5A, -1, 1'b0);
        apb_rd("stat_frm", 4'h8, 32'h42);
        apb_rd("frm_data", 4'hC, 32'h5A);
        apb_wr(4'h8, 32'h40);
        apb_rd("stat_frm_clr", 4'h8, 32'h0A);

        apb_wr(4'h0, 32'h6);
        send_frame(8'h01, 0, 1'b1);
        apb_rd("stat_par", 4'h8, 32'h22);
        apb_rd("par_data", 4'hC, 32'h01);
        apb_wr(4'h8, 32'h20);

        rxd_drv = 1'b0;
        idle(1);
        rxd_drv = 1'b1;
        idle(20);
        apb_rd("stat_glitch", 4'h8, 32'h0A);

        idle(5);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("tx_q_final", tx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
